// File: rtl/array_10_queue.sv
// FIFO controller around an 8x256 1R1W SRAM with a 2-entry register prefetch
// buffer so dequeue data is always registered; empty queue bypasses the SRAM.
module array_10_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 256
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          io_flush,
  input  logic          io_enq_valid,
  output logic          io_enq_ready,
  input  logic [DW-1:0] io_enq_bits,
  output logic          io_deq_valid,
  input  logic          io_deq_ready,
  output logic [DW-1:0] io_deq_bits,
  output logic [3:0]    io_count,
  output logic [AW-1:0] sram_R0_addr,
  output logic          sram_R0_en,
  input  logic [DW-1:0] sram_R0_data,
  output logic [AW-1:0] sram_W0_addr,
  output logic          sram_W0_en,
  output logic [DW-1:0] sram_W0_data
);

  localparam int CNTW = AW + 1;

  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNTW-1:0]      sram_cnt_q, sram_cnt_d;
  logic                 inflight_q, inflight_d;
  logic [1:0][DW-1:0]   pf_q, pf_d;
  logic [1:0]           pf_cnt_q, pf_cnt_d;

  logic                 enq_fire, deq_fire, bypass, wr, rd;
  logic [2:0]           pf_room;
  logic [1:0]           pf_base;

  assign io_count     = 4'(sram_cnt_q) + 4'(inflight_q) + 4'(pf_cnt_q);
  assign io_enq_ready = !io_flush && (io_count < 4'(DEPTH + 2));
  assign io_deq_valid = !io_flush && (pf_cnt_q != 2'd0);
  assign io_deq_bits  = pf_q[0];

  assign enq_fire = io_enq_valid && io_enq_ready;
  assign deq_fire = io_deq_valid && io_deq_ready;

  // Prefetch occupancy after this cycle's pop, counting the read already in flight.
  assign pf_room = {1'b0, pf_cnt_q} - {2'b0, deq_fire} + {2'b0, inflight_q};
  assign pf_base = pf_cnt_q - {1'b0, deq_fire};

  assign bypass = enq_fire && (sram_cnt_q == '0) && !inflight_q && (pf_room < 3'd2);
  assign wr     = enq_fire && !bypass;
  assign rd     = !io_flush && (sram_cnt_q != '0) && (pf_room < 3'd2);

  assign sram_W0_en   = wr;
  assign sram_W0_addr = wptr_q;
  assign sram_W0_data = io_enq_bits;
  assign sram_R0_en   = rd;
  assign sram_R0_addr = rptr_q;

  always_comb begin
    pf_d       = pf_q;
    pf_cnt_d   = pf_base + {1'b0, (inflight_q || bypass)};
    sram_cnt_d = sram_cnt_q + CNTW'(wr) - CNTW'(rd);
    wptr_d     = wptr_q + AW'(wr);
    rptr_d     = rptr_q + AW'(rd);
    inflight_d = rd;
    if (deq_fire) pf_d[0] = pf_q[1];
    // Returning read and bypass are exclusive: bypass needs no read in flight.
    if (inflight_q)  pf_d[pf_base[0]] = sram_R0_data;
    else if (bypass) pf_d[pf_base[0]] = io_enq_bits;
    if (io_flush) begin
      pf_d       = '0;
      pf_cnt_d   = '0;
      sram_cnt_d = '0;
      wptr_d     = '0;
      rptr_d     = '0;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      sram_cnt_q <= '0;
      inflight_q <= 1'b0;
      pf_q       <= '0;
      pf_cnt_q   <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      sram_cnt_q <= sram_cnt_d;
      inflight_q <= inflight_d;
      pf_q       <= pf_d;
      pf_cnt_q   <= pf_cnt_d;
    end
  end

endmodule

// File: tb/tb_array_10_queue.sv
// Scoreboard bench for array_10_queue with a behavioural 1-cycle-latency SRAM.
module tb_array_10_queue;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 256;

  logic          clock = 1'b0;
  logic          reset_n, io_flush, io_enq_valid, io_enq_ready;
  logic [DW-1:0] io_enq_bits, io_deq_bits, sram_R0_data, sram_W0_data;
  logic          io_deq_valid, io_deq_ready;
  logic [3:0]    io_count;
  logic [AW-1:0] sram_R0_addr, sram_W0_addr;
  logic          sram_R0_en, sram_W0_en;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] q[$];
  int checks = 0;
  int failures = 0;

  array_10_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clock(clock), .reset_n(reset_n), .io_flush(io_flush),
    .io_enq_valid(io_enq_valid), .io_enq_ready(io_enq_ready), .io_enq_bits(io_enq_bits),
    .io_deq_valid(io_deq_valid), .io_deq_ready(io_deq_ready), .io_deq_bits(io_deq_bits),
    .io_count(io_count),
    .sram_R0_addr(sram_R0_addr), .sram_R0_en(sram_R0_en), .sram_R0_data(sram_R0_data),
    .sram_W0_addr(sram_W0_addr), .sram_W0_en(sram_W0_en), .sram_W0_data(sram_W0_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (sram_W0_en) mem[sram_W0_addr] <= sram_W0_data;
    if (sram_R0_en) sram_R0_data <= mem[sram_R0_addr];
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: occupancy, ordering and SRAM port sanity against the reference queue.
  always @(negedge clock) begin
    logic [DW-1:0] e;
    if (!reset_n) q.delete();
    else begin
      chk("count_vs_model", DW'(io_count), DW'(q.size()));
      if (sram_R0_en && sram_W0_en) chk("rw_same_addr", DW'(sram_R0_addr != sram_W0_addr), 1);
      if (io_flush) chk("flush_idle", DW'({sram_R0_en, sram_W0_en, io_enq_ready, io_deq_valid}), 0);
      if (io_deq_valid && io_deq_ready) begin
        if (q.size() == 0) chk("deq_when_model_empty", 1, 0);
        else begin
          e = q.pop_front();
          chk("deq_data", io_deq_bits, e);
        end
      end
      if (io_enq_valid && io_enq_ready) q.push_back(io_enq_bits);
      if (io_flush) q.delete();
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [DW-1:0] a5, nv;
    a5 = {32{8'hA5}};
    reset_n = 1'b0; io_flush = 1'b0; io_enq_valid = 1'b0; io_enq_bits = '0; io_deq_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("rst_enq_ready", DW'(io_enq_ready), 1);
    chk("rst_deq_valid", DW'(io_deq_valid), 0);
    chk("rst_count", DW'(io_count), 0);
    chk("rst_enables", DW'({sram_R0_en, sram_W0_en}), 0);
    chk("rst_deq_bits", io_deq_bits, 0);

    // Bypass
    tick(); io_enq_valid = 1'b1; io_enq_bits = a5; io_deq_ready = 1'b1;
    @(negedge clock); chk("byp_no_sram_write", DW'(sram_W0_en), 0);
    tick(); io_enq_valid = 1'b0;
    @(negedge clock);
    chk("byp_deq_valid", DW'(io_deq_valid), 1);
    chk("byp_deq_bits", io_deq_bits, a5);
    chk("byp_count1", DW'(io_count), 1);
    chk("byp_no_sram_write2", DW'(sram_W0_en), 0);
    tick(); @(negedge clock); chk("byp_count0", DW'(io_count), 0);

    // Fill 0..11 with no consumer: 10 accepted
    io_deq_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(); io_enq_valid = 1'b1; io_enq_bits = DW'(i);
      @(negedge clock);
      chk("fill_enq_ready", DW'(io_enq_ready), DW'(i < 10));
    end
    tick(); io_enq_valid = 1'b0;
    @(negedge clock);
    chk("fill_count", DW'(io_count), 10);
    chk("fill_enq_ready_low", DW'(io_enq_ready), 0);
    chk("fill_head", io_deq_bits, 0);
    for (int i = 0; i < DEPTH; i++) chk("fill_sram", mem[i], DW'(i + 2));

    // Stream from full: one deq per cycle, reads every cycle
    io_deq_ready = 1'b1; nv = 12;
    for (int c = 0; c < 30; c++) begin
      tick(); io_enq_valid = 1'b1; io_enq_bits = nv;
      @(negedge clock);
      chk("stream_no_bubble", DW'(io_deq_valid), 1);
      chk("stream_read", DW'(sram_R0_en), 1);
      if (io_enq_ready) nv = nv + 1;
    end
    tick(); io_enq_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (io_count == 0) break;
      tick();
    end
    chk("stream_drained", DW'(io_count), 0);

    // Random backpressure
    for (int c = 0; c < 2000; c++) begin
      tick();
      io_enq_valid = 1'($urandom_range(0, 1));
      io_enq_bits  = rnd();
      io_deq_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    tick(); io_enq_valid = 1'b0; io_deq_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (io_count == 0) break;
      tick();
    end
    chk("rand_drained", DW'(io_count), 0);

    // Flush with a read in flight
    tick(); io_deq_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); io_enq_valid = 1'b1; io_enq_bits = DW'(100 + i);
      @(negedge clock);
    end
    tick(); io_enq_valid = 1'b0; io_deq_ready = 1'b1;
    @(negedge clock); chk("flush_setup_read", DW'(sram_R0_en), 1);
    tick(); io_flush = 1'b1; io_enq_valid = 1'b1; io_enq_bits = DW'(32'hDEAD);
    @(negedge clock);
    chk("flush_enq_ready", DW'(io_enq_ready), 0);
    chk("flush_deq_valid", DW'(io_deq_valid), 0);
    chk("flush_enables", DW'({sram_R0_en, sram_W0_en}), 0);
    tick(); io_flush = 1'b0; io_enq_valid = 1'b0;
    @(negedge clock);
    chk("post_flush_count", DW'(io_count), 0);
    chk("post_flush_deq_valid", DW'(io_deq_valid), 0);
    tick(); io_enq_valid = 1'b1; io_enq_bits = DW'(8'h77);
    @(negedge clock); chk("post_flush_bypass", DW'(sram_W0_en), 0);
    tick(); io_enq_valid = 1'b0;
    @(negedge clock);
    chk("post_flush_deq_valid2", DW'(io_deq_valid), 1);
    chk("post_flush_deq_bits", io_deq_bits, DW'(8'h77));

    // Asynchronous reset mid-stream
    tick(); io_deq_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick(); io_enq_valid = 1'b1; io_enq_bits = DW'(200 + i);
      @(negedge clock);
    end
    tick(); io_enq_valid = 1'b0;
    @(negedge clock); chk("pre_reset_count", DW'(io_count), 7);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_count", DW'(io_count), 0);
    chk("arst_deq_valid", DW'(io_deq_valid), 0);
    chk("arst_deq_bits", io_deq_bits, 0);
    chk("arst_enables", DW'({sram_R0_en, sram_W0_en}), 0);
    @(negedge clock);
    tick(); reset_n = 1'b1; io_enq_valid = 1'b1; io_enq_bits = DW'(1); io_deq_ready = 1'b1;
    @(negedge clock);
    tick(); io_enq_valid = 1'b0;
    @(negedge clock);
    chk("post_rst_deq_valid", DW'(io_deq_valid), 1);
    chk("post_rst_deq_bits", io_deq_bits, DW'(1));
    tick(); @(negedge clock);
    chk("final_model_empty", DW'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
